instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Requester side of the instruction-memory read handshake. Owns the PC, issues one read at a time (ReadEnable pulse, wait for Ack), and presents each fetched word to decode through a valid/stall output register. Handles branch/jump redirects, including redirects that arrive while a read is outstanding. Sits between the IF-stage PC logic and instruction_memory.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded by reset.
- PC_STEP, 4, byte increment per sequential fetch; matches the 32-bit memory word.

- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high; clock CLK.
- address  out  32  byte address of the current request; equals the PC.
- ReadEnable  out  1  one-cycle request pulse to memory.
- Ack  in  1  one-cycle response strobe; Instr is valid in the same cycle.
- Instr  in  32  instruction word from memory.
- Redirect  in  1  load RedirectPC and flush; highest priority.
- RedirectPC  in  32  redirect target; word-aligned by the producer.
- Stall  in  1  decode cannot accept this cycle.
- InstrValid  out  1  InstrOut/InstrPC hold a fetched instruction.
- InstrOut  out  32  fetched instruction.
- InstrPC  out  32  byte address InstrOut was fetched from.

## Operation
- PC register pc drives address directly.
- ReadEnable is decoded from the state register only, with no combinational input-to-output path.
- FSM states:
  - IDLE: reset state, lasts one cycle. Next state is REQ.
  - REQ: ReadEnable=1. Next state is WAIT. If Redirect is also high, the request is already on the bus, so set discard and load pc<=RedirectPC.
  - WAIT: ReadEnable=0. Stays in WAIT until Ack.
    - Ack with discard=1: clear discard, go to REQ.
    - Ack with discard=0: InstrOut<=Instr, InstrPC<=pc, InstrValid<=1, pc<=pc+PC_STEP, go to OUT.
    - Redirect (with or without Ack): pc<=RedirectPC. If Ack is present, drop it and go to REQ. If no Ack, set discard and stay in WAIT.
  - OUT: InstrValid=1. The instruction is accepted in any cycle where Stall=0, then InstrValid<=0 and go to REQ. While Stall=1, stay in OUT with all outputs stable. Redirect: InstrValid<=0, pc<=RedirectPC, go to REQ.
- Ack outside WAIT is ignored; it produces no state or output change.
- pc+PC_STEP wraps modulo 2^32, with no error.
- At most one outstanding request; discard is a single bit.

## Timing
- Reset values: ReadEnable=0, address=RESET_PC, InstrValid=0, InstrOut=0, InstrPC=0, discard=0, state IDLE.
- RST mid-operation wins over everything: the outstanding request is abandoned and discard is cleared. Memory shares RST, so no stale Ack follows.
- Cycle-level sequence with a 1-cycle-latency memory:
  - c0: REQ, ReadEnable=1.
  - c1: Ack.
  - c2: OUT, InstrValid=1.
  - c3: REQ again if Stall=0 in c2.
  - Throughput is one instruction per 3 cycles.
- The first ReadEnable after RST falls is 2 cycles later (IDLE, then REQ).
- Redirect takes effect on the next edge. No instruction from the old stream has InstrValid=1 after that edge.
- Arbitrary Ack latency is tolerated; WAIT has no timeout.

## Structure
- Shared package if_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, OUT}.
  - PC_STEP default.
  - RESET_PC default.
- Single module, no sub-module. The FSM, pc, discard and output register are small enough to keep flat.

## Test plan
- Reset then free-run, memory holding 0x11111111, 0x22222222, 0x33333333 at 0, 4, 8 → ReadEnable at c2, c5, c8. InstrValid emits PC/word pairs 0/0x11111111, 4/0x22222222, 8/0x33333333.
- Hold Stall=1 for 4 cycles while InstrValid=1 → InstrOut/InstrPC stable, no ReadEnable. The next ReadEnable comes the cycle after Stall falls.
- Redirect to 0x40 in a WAIT cycle with no Ack → the Ack one cycle later is dropped. Next ReadEnable has address 0x40. The first valid output is InstrPC=0x40.
- Redirect to 0x80 in the same cycle as Ack → response dropped. REQ follows with address 0x80.
- Redirect in OUT while Stall=1 → InstrValid=0 next cycle, then ReadEnable with address RedirectPC.
- RESET_PC=32'hFFFF_FFFC → second request address is 0x0000_0000 (wrap). Assert RST during WAIT → all outputs return to reset values.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and default constants for the instruction fetch
//               unit.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_PC_STEP  = 32'd4;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Owns the PC, issues one instruction-memory read at a time and
//               presents fetched words to decode through a valid/stall register.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] PC_STEP  = c_PC_STEP
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] address,
    output logic        ReadEnable,
    input  logic        Ack,
    input  logic [31:0] Instr,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Stall,
    output logic        InstrValid,
    output logic [31:0] InstrOut,
    output logic [31:0] InstrPC
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [31:0] r_pc;
    logic        r_discard;
    logic        r_instr_valid;
    logic [31:0] r_instr_out;
    logic [31:0] r_instr_pc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: w_next_state = REQ;
            REQ:  w_next_state = WAIT;
            WAIT: begin
                if (Redirect) begin
                    w_next_state = Ack ? REQ : WAIT;
                end else if (Ack) begin
                    w_next_state = r_discard ? REQ : OUT;
                end
            end
            OUT: begin
                if (Redirect || !Stall) begin
                    w_next_state = REQ;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath follows the same state decode; a redirect always wins over Ack/Stall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc          <= RESET_PC;
            r_discard     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr_out   <= 32'h0;
            r_instr_pc    <= 32'h0;
        end else begin
            case (r_state)
                REQ: begin
                    // The request is already on the bus; its response must be dropped.
                    if (Redirect) begin
                        r_pc      <= RedirectPC;
                        r_discard <= 1'b1;
                    end
                end
                WAIT: begin
                    if (Redirect) begin
                        r_pc      <= RedirectPC;
                        r_discard <= ~Ack;
                    end else if (Ack) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                        end else begin
                            r_instr_out   <= Instr;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= r_pc + PC_STEP;
                        end
                    end
                end
                OUT: begin
                    if (Redirect) begin
                        r_pc          <= RedirectPC;
                        r_instr_valid <= 1'b0;
                    end else if (!Stall) begin
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign address    = r_pc;
    assign ReadEnable = (r_state == REQ);
    assign InstrValid = r_instr_valid;
    assign InstrOut   = r_instr_out;
    assign InstrPC    = r_instr_pc;

endmodule
`default_nettype wire
